// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register map
// and STATUS field layout.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_INSVC = 2'd2
    } irq_state_e;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;

    localparam int STATUS_STATE_LSB = 0;
    localparam int STATUS_STATE_W   = 2;
    localparam int STATUS_ID_LSB    = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: SYNC_STAGES-deep synchroniser followed by a
// rising-edge detector on the synchronised level.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_src,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_src};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with ENABLE/PENDING/STATUS registers and
// ack/eoi handshake. Define IRQ_CTRL_NESTING_EN for preemptive nesting.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int               N_SRC       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_SRC-1:0] LEVEL_MASK  = '0,
    localparam int              ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_src,
    input  logic             i_we,
    input  logic [1:0]       i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    output logic             o_irq,
    output logic [ID_W-1:0]  o_irq_id,
    input  logic             i_ack,
    input  logic             i_eoi
);

    function automatic logic [ID_W-1:0] lowest_idx(input logic [N_SRC-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction

    logic [N_SRC-1:0] lvl, rise;
    logic [N_SRC-1:0] pend_q, pend_d, en_q, en_d;
    logic [N_SRC-1:0] elig, elig_nxt, w1c, ack_clr;
    irq_state_e       state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d, svc_id;
    logic             unused_wdata;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_src   (i_src[g]),
            .o_level (lvl[g]),
            .o_rise  (rise[g])
        );
    end

`ifdef IRQ_CTRL_NESTING_EN
    logic [N_SRC-1:0] svc_q, svc_d, svc_top;
    assign svc_top = svc_q & (~svc_q + N_SRC'(1));
    assign svc_id  = lowest_idx(svc_q);
`else
    logic [ID_W-1:0] svc_q, svc_d;
    assign svc_id = svc_q;
`endif

    assign unused_wdata = ^i_wdata;

    // A fresh edge overrides a same-cycle W1C or ack clear so no event is lost.
    always_comb begin
        w1c     = (i_we && i_addr == ADDR_PENDING) ? i_wdata[N_SRC-1:0] : '0;
        ack_clr = (state_q == ST_REQ && i_ack) ? (N_SRC'(1) << id_q) : '0;
        pend_d  = (LEVEL_MASK & lvl) |
                  (~LEVEL_MASK & (rise | (pend_q & ~(w1c | ack_clr))));
        en_d    = (i_we && i_addr == ADDR_ENABLE) ? i_wdata[N_SRC-1:0] : en_q;
    end

    assign elig     = pend_q & en_q;
    assign elig_nxt = pend_d & en_d;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        svc_d   = svc_q;
        case (state_q)
            ST_IDLE: begin
                if (|elig) begin
                    state_d = ST_REQ;
                    id_d    = lowest_idx(elig);
                end
            end
            ST_REQ: begin
                if (i_ack) begin
                    state_d = ST_INSVC;
`ifdef IRQ_CTRL_NESTING_EN
                    svc_d = svc_q | (N_SRC'(1) << id_q);
`else
                    svc_d = id_q;
`endif
                end else if (!elig_nxt[id_q]) begin
                    // Withdrawn request falls back to whatever handler was interrupted.
`ifdef IRQ_CTRL_NESTING_EN
                    state_d = (|svc_q) ? ST_INSVC : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_INSVC: begin
`ifdef IRQ_CTRL_NESTING_EN
                if (i_eoi) begin
                    svc_d = svc_q & ~svc_top;
                    if (svc_d == '0) state_d = ST_IDLE;
                end else if ((elig & (svc_top - N_SRC'(1))) != '0) begin
                    state_d = ST_REQ;
                    id_d    = lowest_idx(elig);
                end
`else
                if (i_eoi) begin
                    state_d = ST_IDLE;
                    svc_d   = '0;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_q  <= '0;
            en_q    <= '0;
            state_q <= ST_IDLE;
            id_q    <= '0;
            svc_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            en_q    <= en_d;
            state_q <= state_d;
            id_q    <= id_d;
            svc_q   <= svc_d;
        end
    end

    assign o_irq    = (state_q == ST_REQ);
    assign o_irq_id = id_q;

    always_comb begin
        o_rdata = '0;
        case (i_addr)
            ADDR_ENABLE:  o_rdata[N_SRC-1:0] = en_q;
            ADDR_PENDING: o_rdata[N_SRC-1:0] = pend_q;
            ADDR_STATUS: begin
                o_rdata[STATUS_STATE_LSB +: STATUS_STATE_W] = state_q;
                o_rdata[STATUS_ID_LSB +: ID_W]              = svc_id;
            end
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (N_SRC=4, SYNC_STAGES=2, all edge-triggered);
// the nesting scenario is built when IRQ_CTRL_NESTING_EN is defined.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src = '0;
    logic        we = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  irq_id;
    logic        ack = 1'b0;
    logic        eoi = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    irq_ctrl #(.N_SRC(4), .SYNC_STAGES(2), .LEVEL_MASK(4'b0000)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_src    (src),
        .i_we     (we),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_rdata  (rdata),
        .o_irq    (irq),
        .o_irq_id (irq_id),
        .i_ack    (ack),
        .i_eoi    (eoi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", tag, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0; wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    logic [31:0] r;

    initial begin
        // Reset state
        #2;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_id", {30'd0, irq_id}, 32'd0);
        rd(2'd0, r); check("rst_enable", r, 32'h0);
        rd(2'd1, r); check("rst_pending", r, 32'h0);
        rd(2'd2, r); check("rst_status", r, 32'h0);
        #2 rst = 1'b0;
        tick();

        // Single edge on source 3
        wr(2'd0, 32'hF);
        rd(2'd0, r); check("enable_rb", r, 32'hF);
        src[3] = 1'b1;
        tick(2);
        rd(2'd1, r); check("t1_pend_early", r, 32'h0);
        tick();
        src[3] = 1'b0;
        rd(2'd1, r); check("t1_pend", r, 32'h8);
        check("t1_irq_early", {31'd0, irq}, 32'd0);
        tick();
        check("t1_irq", {31'd0, irq}, 32'd1);
        check("t1_id", {30'd0, irq_id}, 32'd3);
        pulse_ack();
        check("t1_irq_ack", {31'd0, irq}, 32'd0);
        rd(2'd1, r); check("t1_pend_ack", r, 32'h0);
        rd(2'd2, r); check("t1_status_insvc", r, 32'h302);
        pulse_eoi();
        rd(2'd2, r); check("t1_status_idle", r, 32'h0);
        check("t1_irq_eoi", {31'd0, irq}, 32'd0);

        // Two simultaneous edges: priority then second request
        src[1] = 1'b1; src[2] = 1'b1;
        tick(3);
        src[1] = 1'b0; src[2] = 1'b0;
        rd(2'd1, r); check("t2_pend", r, 32'h6);
        tick();
        check("t2_irq", {31'd0, irq}, 32'd1);
        check("t2_id1", {30'd0, irq_id}, 32'd1);
        pulse_ack();
        rd(2'd1, r); check("t2_pend_ack", r, 32'h4);
        pulse_eoi();
        check("t2_irq_idle", {31'd0, irq}, 32'd0);
        tick();
        check("t2_irq2", {31'd0, irq}, 32'd1);
        check("t2_id2", {30'd0, irq_id}, 32'd2);
        pulse_ack();
        pulse_eoi();

        // Masked source, then enabled
        wr(2'd0, 32'h0);
        src[0] = 1'b1;
        tick(3);
        src[0] = 1'b0;
        tick();
        rd(2'd1, r); check("t3_pend_masked", r, 32'h1);
        check("t3_irq_masked", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'h1);
        tick();
        check("t3_irq_en", {31'd0, irq}, 32'd1);
        check("t3_id_en", {30'd0, irq_id}, 32'd0);
        pulse_ack();
        pulse_eoi();
        wr(2'd0, 32'hF);

        // W1C withdraws a pending request
        src[2] = 1'b1;
        tick(3);
        src[2] = 1'b0;
        tick();
        check("t4_irq", {31'd0, irq}, 32'd1);
        check("t4_id", {30'd0, irq_id}, 32'd2);
        wr(2'd1, 32'h4);
        check("t4_irq_w1c", {31'd0, irq}, 32'd0);
        rd(2'd2, r); check("t4_status_w1c", r, 32'h0);
        rd(2'd1, r); check("t4_pend_w1c", r, 32'h0);

        // W1C coinciding with a fresh edge: set wins
        src[2] = 1'b1;
        tick(3);
        src[2] = 1'b0;
        tick();
        check("t4b_irq", {31'd0, irq}, 32'd1);
        tick(2);
        src[2] = 1'b1;
        tick(2);
        wr(2'd1, 32'h4);
        src[2] = 1'b0;
        rd(2'd1, r); check("t4b_pend_kept", r, 32'h4);
        check("t4b_irq_kept", {31'd0, irq}, 32'd1);
        check("t4b_id_kept", {30'd0, irq_id}, 32'd2);
        pulse_ack();
        rd(2'd1, r); check("t4b_pend_ack", r, 32'h0);
        pulse_eoi();
        tick(3);

`ifdef IRQ_CTRL_NESTING_EN
        // Preemption of handler 3 by source 0
        src[3] = 1'b1;
        tick(3);
        src[3] = 1'b0;
        tick();
        check("n_id3", {30'd0, irq_id}, 32'd3);
        pulse_ack();
        src[0] = 1'b1;
        tick(3);
        src[0] = 1'b0;
        tick();
        check("n_irq0", {31'd0, irq}, 32'd1);
        check("n_id0", {30'd0, irq_id}, 32'd0);
        pulse_ack();
        rd(2'd2, r); check("n_status_nested", r, 32'h002);
        pulse_eoi();
        rd(2'd2, r); check("n_status_back3", r, 32'h302);
        pulse_eoi();
        rd(2'd2, r); check("n_status_idle", r, 32'h0);
`endif

        // Async reset while in service
        src[3] = 1'b1;
        tick(3);
        src[3] = 1'b0;
        tick();
        pulse_ack();
        rd(2'd2, r); check("t5_status_pre", r, 32'h302);
        #1 rst = 1'b1;
        #1;
        check("t5_irq_rst", {31'd0, irq}, 32'd0);
        rd(2'd2, r); check("t5_status_rst", r, 32'h0);
        rd(2'd0, r); check("t5_enable_rst", r, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller between raw asynchronous sources (board buttons, peripherals) and the RISC core's trap logic.
- Synchronises N_SRC sources, latches pending events and applies a software enable mask.
- Presents one fixed-priority request with an ID, and tracks in-service state through an ack/end-of-interrupt handshake with the core.
- Successor to the single-purpose button interrupt path: generalised source count, mixed edge/level triggering, register-mapped mask and pending.

Parameters:
N_SRC, 4, number of interrupt sources (1..32)
SYNC_STAGES, 2, synchroniser flops per source (>=2)
LEVEL_MASK, '0 (N_SRC bits), bit i = 1 makes source i level-triggered, 0 makes it rising-edge-triggered
ID_W (localparam), $clog2(N_SRC) min 1, width of interrupt ID

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_src  in  N_SRC  raw asynchronous interrupt sources
i_we  in  1  register write strobe
i_addr  in  2  register select: 0 ENABLE, 1 PENDING, 2 STATUS, 3 reserved (reads 0)
i_wdata  in  32  write data
o_rdata  out  32  read data, combinational from i_addr
o_irq  out  1  interrupt request to core, registered
o_irq_id  out  ID_W  ID of requested source, registered, valid while o_irq=1
i_ack  in  1  core accepts request (single-cycle pulse)
i_eoi  in  1  handler finished (mret), single-cycle pulse

Behaviour:
- Reset (async, i_rst=1): all synchronisers, pending, ENABLE, in-service and FSM registers cleared. State is IDLE; o_irq=0; o_irq_id=0; o_rdata reads 0 for ENABLE and PENDING.
- Sync: each source passes SYNC_STAGES flops. Edge sources set pending[i] on a synced 0->1 transition; pending holds until cleared. Level sources: pending[i] = synced level every cycle; W1C and ack have no effect on them.
- Eligible = pending & ENABLE. Winner = lowest eligible index (bit 0 highest priority).
- Latency: i_src rising edge -> pending set after SYNC_STAGES+1 clocks -> o_irq=1 on the following clock.
- ENABLE (addr 0): R/W, bits [N_SRC-1:0]; write effective next cycle.
- PENDING (addr 1): read; write-1-to-clear for edge sources.
- STATUS (addr 2): [1:0] FSM state, [8+ID_W-1:8] current in-service ID.
- Unused read bits return 0.
- FSM:
  - IDLE: o_irq=0. Any eligible -> REQ; latch winner into o_irq_id.
  - REQ: o_irq=1, o_irq_id held stable. i_ack -> clear pending[id] (edge), set in-service[id], go to INSVC. If latched source stops being eligible before ack (W1C, disable, level drop) -> IDLE, o_irq=0 next cycle.
  - INSVC: o_irq=0. New events still set pending. i_eoi -> clear in-service, go to IDLE.
- i_ack outside REQ and i_eoi outside INSVC are ignored.
- Same-cycle set vs clear on one pending bit (edge with ack, or edge with W1C): set wins; the event is not lost.
- i_ack and a register write in the same cycle: both take effect.

Optional Feature:
- Macro IRQ_CTRL_NESTING_EN.
- Defined:
  - In-service is a N_SRC-bit vector.
  - In INSVC, an eligible source with index lower than the highest-priority in-service bit re-enters REQ, preempting the current handler.
  - i_eoi clears the highest-priority in-service bit; the FSM returns to IDLE only when the vector is zero, otherwise stays in INSVC.
  - STATUS[8+ID_W-1:8] reports the highest-priority active in-service ID.
- Undefined: single in-service ID register, no preemption in INSVC.

Decomposition:
- Package irq_ctrl_pkg: FSM state enum (IDLE=0, REQ=1, INSVC=2); register address constants ADDR_ENABLE, ADDR_PENDING, ADDR_STATUS; STATUS field offsets.
- Sub-module irq_sync_edge: per-source SYNC_STAGES synchroniser plus rising-edge detector, instantiated N_SRC times via generate.

Test Plan (N_SRC=4, SYNC_STAGES=2, LEVEL_MASK=4'b0000):
- Reset, write ENABLE=4'hF, pulse i_src[3] -> pending=4'h8 after 3 clocks; o_irq=1, o_irq_id=3 one clock later; i_ack -> pending=0, STATUS state=2; i_eoi -> IDLE, o_irq=0.
- Raise i_src[1] and i_src[2] in the same cycle -> o_irq_id=1; after ack+eoi -> second request with o_irq_id=2.
- ENABLE=4'h0, pulse i_src[0] -> PENDING reads 4'h1, o_irq stays 0; write ENABLE=4'h1 -> o_irq=1 with id 0 within 2 clocks.
- In REQ for id 2, write PENDING=4'h4 (W1C) -> o_irq drops next cycle, state IDLE; repeat with edge arriving in the W1C cycle -> pending stays set.
- Assert i_rst mid-INSVC -> o_irq=0, STATUS=0, ENABLE=0 immediately, without waiting for a clock edge.
- With IRQ_CTRL_NESTING_EN: in INSVC for id 3, pulse i_src[0] -> o_irq=1 id 0; ack, eoi -> remains INSVC with in-service id 3; second eoi -> IDLE.
